// File: rtl/stage3_pkg.sv
// Shared widths, limits and FSM encoding for the stage-3 accumulator.
package stage3_pkg;
  localparam int PW_DEF    = 14;
  localparam int NUM_LANES = 9;
  localparam int GRP_W     = 16;
  localparam int SUM_W     = 18;
  localparam int PIX_MAX   = 255;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;
endpackage

// File: rtl/stage3_add3.sv
// Combinational signed three-input adder with sign-extending output.
module stage3_add3 #(
  parameter int IW = 14,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] a,
  input  logic signed [IW-1:0] b,
  input  logic signed [IW-1:0] c,
  output logic signed [OW-1:0] y
);
  assign y = OW'(a) + OW'(b) + OW'(c);
endmodule

// File: rtl/stage3_accumulate.sv
// Stage 3: gathers a 3x3 product window, sums it in a 2-level adder tree,
// normalises and saturates to an 8-bit pixel; tracks run pixel count.
module stage3_accumulate
  import stage3_pkg::*;
#(
  parameter int PW         = PW_DEF,
  parameter int NORM_SHIFT = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stage3_start,
  input  logic [PW-1:0]    prod1,
  input  logic [PW-1:0]    prod2,
  input  logic [PW-1:0]    prod3,
  input  logic [PW-1:0]    prod4,
  input  logic [PW-1:0]    prod5,
  input  logic [PW-1:0]    prod6,
  input  logic [PW-1:0]    prod7,
  input  logic [PW-1:0]    prod8,
  input  logic [PW-1:0]    prod9,
  input  logic             prod1_valid,
  input  logic             prod2_valid,
  input  logic             prod3_valid,
  input  logic             prod4_valid,
  input  logic             prod5_valid,
  input  logic             prod6_valid,
  input  logic             prod7_valid,
  input  logic             prod8_valid,
  input  logic             prod9_valid,
  output logic [7:0]       pixel_out,
  output logic             pixel_valid,
  output logic [CNT_W-1:0] pixel_count,
  output logic             window_dropped,
  output logic             stage3_done
);
  localparam int STAGES = 3;
  localparam logic signed [SUM_W-1:0] T_MAX = SUM_W'(PIX_MAX);

  state_t state;

  logic [NUM_LANES-1:0][PW-1:0] prod_in, win_q, merged;
  logic [NUM_LANES-1:0]         vin, got_q;
  logic [2:0][GRP_W-1:0]        grp_d, grp_q;
  logic signed [SUM_W-1:0]      sum_d, sum_q, t;
  logic [STAGES-1:0]            vld_pipe;
  logic [7:0]                   pix_d;
  logic                         launch;

  assign prod_in = {prod9, prod8, prod7, prod6, prod5, prod4, prod3, prod2, prod1};
  assign vin     = {prod9_valid, prod8_valid, prod7_valid, prod6_valid, prod5_valid,
                    prod4_valid, prod3_valid, prod2_valid, prod1_valid};

  // Lanes arriving on the completing edge belong to the launched window.
  assign launch = (state == S_COLLECT) && ((got_q | vin) == '1);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged[i] = vin[i] ? prod_in[i] : win_q[i];
  end

  for (genvar g = 0; g < 3; g++) begin : g_grp
    stage3_add3 #(.IW(PW), .OW(GRP_W)) u_grp (
      .a(merged[3*g]), .b(merged[3*g+1]), .c(merged[3*g+2]), .y(grp_d[g])
    );
  end

  stage3_add3 #(.IW(GRP_W), .OW(SUM_W)) u_sum (
    .a(grp_q[0]), .b(grp_q[1]), .c(grp_q[2]), .y(sum_d)
  );

  always_comb begin
    t = sum_q >>> NORM_SHIFT;
    if (t[SUM_W-1])   pix_d = 8'd0;
    else if (t > T_MAX) pix_d = 8'(PIX_MAX);
    else              pix_d = t[7:0];
  end

  assign pixel_valid = vld_pipe[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      got_q          <= '0;
      win_q          <= '0;
      grp_q          <= '0;
      sum_q          <= '0;
      vld_pipe       <= '0;
      pixel_out      <= '0;
      pixel_count    <= '0;
      window_dropped <= 1'b0;
      stage3_done    <= 1'b0;
    end else begin
      window_dropped <= 1'b0;
      stage3_done    <= 1'b0;
      vld_pipe       <= {vld_pipe[STAGES-2:0], launch};
      if (launch)      grp_q <= grp_d;
      if (vld_pipe[0]) sum_q <= sum_d;
      if (vld_pipe[1]) begin
        pixel_out   <= pix_d;
        pixel_count <= pixel_count + CNT_W'(1);
      end
      case (state)
        S_IDLE: if (stage3_start) begin
          state       <= S_COLLECT;
          pixel_count <= '0;
        end
        S_COLLECT: begin
          for (int i = 0; i < NUM_LANES; i++)
            if (vin[i]) win_q[i] <= prod_in[i];
          got_q <= launch ? '0 : (got_q | vin);
          // A partial window left behind at run end is discarded and flagged.
          if (!stage3_start) begin
            state          <= S_DRAIN;
            got_q          <= '0;
            window_dropped <= !launch && (|(got_q | vin));
          end
        end
        S_DRAIN: if (vld_pipe == '0) begin
          stage3_done <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
